// File: rtl/axis_check_sink.sv
// AXI-Stream checker sink: counts frames and data/keep/dest/length errors; results appear one cycle after the accepting edge.
// tready is high throughout RUN, or follows an LFSR when AXIS_CHK_BACKPRESSURE_EN is defined.
module axis_check_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 16,
    parameter int NUM_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [3:0]              S_AXIS_tdest,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tlast,
    input  logic                    S_AXIS_tvalid,
    output logic                    S_AXIS_tready,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             err_cnt,
    output logic [3:0]              err_flags
);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $fatal(1, "axis_check_sink: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [15:0] NF       = 16'(NUM_FRAMES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    tready_q, tready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [3:0]              err_flags_q, err_flags_d;
    logic [15:0]             beat_idx_q, beat_idx_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;

    logic                    accept;
    logic                    at_last_idx;
    logic                    enter_run;
    logic [3:0]              errs;
    logic [16:0]             err_sum;

`ifdef AXIS_CHK_BACKPRESSURE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flags_d = err_flags_q;
        beat_idx_d  = beat_idx_q;
        exp_d       = exp_q;

        accept      = S_AXIS_tvalid && tready_q;
        at_last_idx = (beat_idx_q == LAST_IDX);
        enter_run   = (state_q != RUN) && start;
        errs        = {S_AXIS_tdest != 4'd0,
                       S_AXIS_tkeep != {(DATA_WIDTH/8){1'b1}},
                       S_AXIS_tlast ^ at_last_idx,
                       S_AXIS_tdata != exp_q};
        err_sum     = 17'(err_cnt_q) + 17'(errs[0]) + 17'(errs[1])
                    + 17'(errs[2]) + 17'(errs[3]);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    frame_cnt_d = '0;
                    err_cnt_d   = '0;
                    err_flags_d = '0;
                    beat_idx_d  = '0;
                    exp_d       = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    err_flags_d = err_flags_q | errs;
                    err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                    // Resynchronise on whatever arrived so one glitch costs one error.
                    exp_d       = S_AXIS_tdata + DATA_WIDTH'(1);
                    if (S_AXIS_tlast || at_last_idx) begin
                        beat_idx_d  = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (frame_cnt_q + 16'd1 == NF) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == RUN);
        done_d   = (state_d == DONE);
`ifdef AXIS_CHK_BACKPRESSURE_EN
        lfsr_d = lfsr_q;
        if (enter_run) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == RUN) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        tready_d = (state_d == RUN) && lfsr_d[0];
`else
        tready_d = (state_d == RUN);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_flags_q <= '0;
            beat_idx_q  <= '0;
            exp_q       <= '0;
`ifdef AXIS_CHK_BACKPRESSURE_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flags_q <= err_flags_d;
            beat_idx_q  <= beat_idx_d;
            exp_q       <= exp_d;
`ifdef AXIS_CHK_BACKPRESSURE_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign S_AXIS_tready = tready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign err_flags     = err_flags_q;

endmodule

// File: tb/tb_axis_check_sink.sv
// Bench for axis_check_sink: scenario table with a beat-level scoreboard, reset-mid-run and an 8-bit wrap run.
module tb_axis_check_sink;

    localparam int DW = 32;
    localparam int FL = 16;
    localparam int NF = 4;
    localparam int NF2 = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic [3:0]    tdest = '0;
    logic [3:0]    tkeep = 4'hF;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready, busy, done;
    logic [15:0]   frame_cnt, err_cnt;
    logic [3:0]    err_flags;

    logic          start2 = 1'b0;
    logic [7:0]    tdata2 = '0;
    logic [3:0]    tdest2 = '0;
    logic [0:0]    tkeep2 = 1'b1;
    logic          tlast2 = 1'b0;
    logic          tvalid2 = 1'b0;
    logic          tready2, busy2, done2;
    logic [15:0]   frame_cnt2, err_cnt2;
    logic [3:0]    err_flags2;

    axis_check_sink #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .NUM_FRAMES(NF)) dut (
        .clk(clk), .rst(rst), .start(start),
        .S_AXIS_tdata(tdata), .S_AXIS_tdest(tdest), .S_AXIS_tkeep(tkeep),
        .S_AXIS_tlast(tlast), .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
        .err_flags(err_flags)
    );

    axis_check_sink #(.DATA_WIDTH(8), .FRAME_LEN(FL), .NUM_FRAMES(NF2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .S_AXIS_tdata(tdata2), .S_AXIS_tdest(tdest2), .S_AXIS_tkeep(tkeep2),
        .S_AXIS_tlast(tlast2), .S_AXIS_tvalid(tvalid2), .S_AXIS_tready(tready2),
        .busy(busy2), .done(done2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2),
        .err_flags(err_flags2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model and scoreboard of per-beat counter state
    typedef struct {
        logic [15:0] fc;
        logic [15:0] ec;
        logic [3:0]  fl;
    } exp_t;
    exp_t sb_q[$];

    logic [DW-1:0] m_exp;
    int            m_idx, m_fc, m_ec;
    logic [3:0]    m_fl;

    task automatic model_reset();
        m_exp = '0; m_idx = 0; m_fc = 0; m_ec = 0; m_fl = '0;
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input logic [3:0] k,
                              input logic [3:0] dst, input logic l);
        logic [3:0] e;
        exp_t       r;
        e[0] = (d != m_exp);
        e[1] = l ? (m_idx != FL - 1) : (m_idx == FL - 1);
        e[2] = (k != 4'hF);
        e[3] = (dst != 4'd0);
        m_fl = m_fl | e;
        m_ec = m_ec + int'(e[0]) + int'(e[1]) + int'(e[2]) + int'(e[3]);
        if (m_ec > 65535) m_ec = 65535;
        m_exp = d + 32'd1;
        if (l || m_idx == FL - 1) begin
            m_idx = 0;
            m_fc++;
        end else begin
            m_idx++;
        end
        r.fc = 16'(m_fc); r.ec = 16'(m_ec); r.fl = m_fl;
        sb_q.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] k,
                             input logic [3:0] dst, input logic l);
        int n;
        tdata = d; tkeep = k; tdest = dst; tlast = l; tvalid = 1'b1;
        n = 0;
        while (!tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            checks++; errors++;
            $display("FAIL tready_timeout: actual=0 expected=1 after %0d cycles", n);
            tvalid = 1'b0;
        end else begin
            model_beat(d, k, dst, l);
            @(negedge clk);
        end
    endtask

    logic acc1 = 1'b0;
    always @(posedge clk) acc1 <= tvalid && tready;

    always @(negedge clk) begin
        exp_t r;
        if (acc1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_beat: actual=accepted expected=none");
            end else begin
                r = sb_q.pop_front();
                chk("sb_frame_cnt", 32'(frame_cnt), 32'(r.fc));
                chk("sb_err_cnt", 32'(err_cnt), 32'(r.ec));
                chk("sb_err_flags", 32'(err_flags), 32'(r.fl));
            end
        end
    end

    int low2 = 0;
    always @(negedge clk) if (busy2 && !tready2) low2++;

    typedef struct {
        string      name;
        int         kind;   // 0 clean, 1 data, 2 early tlast, 3 keep+dest, 4 missing tlast
        int         bad;
        logic [3:0] ef;
        int         ec;
    } scn_t;
    scn_t tbl[5];

    task automatic run_scn(input scn_t s);
        logic [DW-1:0] v, d;
        logic [3:0]    k, dst;
        logic          l;
        int            g, flen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({s.name, "_busy"}, 32'(busy), 32'd1);
        chk({s.name, "_clr_frame"}, 32'(frame_cnt), 32'd0);
        chk({s.name, "_clr_err"}, 32'(err_cnt), 32'd0);
        chk({s.name, "_clr_flags"}, 32'(err_flags), 32'd0);
        model_reset();
        v = '0; g = 0;
        for (int f = 0; f < NF; f++) begin
            flen = (s.kind == 2 && f == 0) ? s.bad + 1 : FL;
            for (int i = 0; i < flen; i++) begin
                d = v; k = 4'hF; dst = 4'd0; l = (i == flen - 1);
                if (g == s.bad) begin
                    case (s.kind)
                        1: d = 32'hDEAD;
                        3: begin k = 4'h7; dst = 4'd3; end
                        4: l = 1'b0;
                        default: ;
                    endcase
                end
                if (s.kind == 0 && g == 30) start = 1'b1;
                send_beat(d, k, dst, l);
                start = 1'b0;
                v = d + 32'd1;
                g++;
                if ($urandom_range(0, 3) == 0) begin
                    tvalid = 1'b0;
                    @(negedge clk);
                end
            end
        end
        tvalid = 1'b0;
        @(negedge clk);
        chk({s.name, "_done"}, 32'(done), 32'd1);
        chk({s.name, "_busy_off"}, 32'(busy), 32'd0);
        chk({s.name, "_tready_off"}, 32'(tready), 32'd0);
        chk({s.name, "_frames"}, 32'(frame_cnt), 32'(NF));
        chk({s.name, "_errs"}, 32'(err_cnt), 32'(s.ec));
        chk({s.name, "_flags"}, 32'(err_flags), 32'(s.ef));
        chk({s.name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{"clean",         0, -1, 4'b0000, 0};
        tbl[1] = '{"data_glitch",   1,  5, 4'b0001, 1};
        tbl[2] = '{"early_tlast",   2,  9, 4'b0010, 1};
        tbl[3] = '{"keep_dest",     3,  7, 4'b1100, 2};
        tbl[4] = '{"missing_tlast", 4, 31, 4'b0010, 1};

        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_frame", 32'(frame_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_flags", 32'(err_flags), 32'd0);
        rst = 1'b0;
        tvalid = 1'b1;
        @(negedge clk);
        chk("idle_tready", 32'(tready), 32'd0);
        tvalid = 1'b0;

        for (int s = 0; s < 5; s++) run_scn(tbl[s]);

        // Reset in the middle of a run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
        for (int g = 0; g < 20; g++) send_beat(32'(g), 4'hF, 4'd0, (g % 16) == 15);
        tvalid = 1'b0;
        @(negedge clk);
        chk("mid_frame_before", 32'(frame_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_tready", 32'(tready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_frame", 32'(frame_cnt), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_flags", 32'(err_flags), 32'd0);
        run_scn(tbl[0]);

        // 8-bit data wrapping over 20 frames with random tvalid
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int b = 0; b < NF2 * FL; b++) begin
            tvalid2 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tdata2 = 8'(b); tlast2 = (b % FL) == FL - 1; tvalid2 = 1'b1;
            n = 0;
            while (!tready2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!tready2) begin
                checks++; errors++;
                $display("FAIL wrap_tready_timeout: actual=0 expected=1 at beat %0d", b);
                break;
            end
            @(negedge clk);
        end
        tvalid2 = 1'b0;
        @(negedge clk);
        chk("wrap_done", 32'(done2), 32'd1);
        chk("wrap_frames", 32'(frame_cnt2), 32'(NF2));
        chk("wrap_errs", 32'(err_cnt2), 32'd0);
        chk("wrap_flags", 32'(err_flags2), 32'd0);
`ifdef AXIS_CHK_BACKPRESSURE_EN
        chk("wrap_tready_low_seen", 32'(low2 != 0), 32'd1);
`else
        chk("wrap_tready_low_cycles", 32'(low2), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_check_sink.md
AXIS_CHECK_SINK -- requirements
Module: axis_check_sink

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the tdata width in bits, which SHALL be a multiple of 8 (elaboration $fatal otherwise).
REQ-002 The block SHALL have parameter FRAME_LEN, default 16, giving the expected beats per frame (range 1..65535).
REQ-003 The block SHALL have parameter NUM_FRAMES, default 4, giving the frames per test run (range 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-007 The block SHALL have port S_AXIS_tdata, input, DATA_WIDTH bits: stream data.
REQ-008 The block SHALL have port S_AXIS_tdest, input, 4 bits: stream destination.
REQ-009 The block SHALL have port S_AXIS_tkeep, input, DATA_WIDTH/8 bits: byte enables.
REQ-010 The block SHALL have port S_AXIS_tlast, input, 1 bit: end of frame.
REQ-011 The block SHALL have port S_AXIS_tvalid, input, 1 bit: upstream data valid.
REQ-012 The block SHALL have port S_AXIS_tready, output, 1 bit: sink ready.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-015 The block SHALL have port frame_cnt, output, 16 bits: frames completed this run.
REQ-016 The block SHALL have port err_cnt, output, 16 bits: saturating error count.
REQ-017 The block SHALL have port err_flags, output, 4 bits: sticky flags {dest, keep, len, data} (bits 3..0).

Function
REQ-018 A beat SHALL be accepted on a rising edge where S_AXIS_tvalid=1 and S_AXIS_tready=1; all other cycles SHALL leave the counters and expected value unchanged.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE on the edge where frame_cnt reaches NUM_FRAMES, and DONE->RUN on start.
REQ-020 Entering RUN SHALL clear frame_cnt, err_cnt, err_flags, the beat index and the expected data (to 0), all in the same edge as the transition.
REQ-021 start while in RUN SHALL be ignored.
REQ-022 S_AXIS_tready SHALL be 0 in IDLE and DONE, and asserted in RUN subject to REQ-033/REQ-034.
REQ-023 The expected data SHALL start at 0 and, after each accepted beat, become the received tdata + 1, modulo 2^DATA_WIDTH (wrap from all-ones to 0 is legal), so that a mismatch is counted once and the check then resynchronises.
REQ-024 A data error SHALL be raised when an accepted tdata differs from the expected data.
REQ-025 A keep error SHALL be raised when an accepted tkeep is not all-ones.
REQ-026 A dest error SHALL be raised when an accepted tdest is not 0.
REQ-027 A length error SHALL be raised when tlast=1 at beat index < FRAME_LEN-1, or when tlast=0 at beat index FRAME_LEN-1.
REQ-028 The beat index SHALL return to 0 after an accepted beat with tlast=1 or at index FRAME_LEN-1 (whichever comes first), and frame_cnt SHALL increment at that same point.
REQ-029 Each error type SHALL set its sticky err_flags bit; err_cnt SHALL add the number of error types raised on that beat (0..4), saturating at 0xFFFF.
REQ-030 All outputs SHALL be registered, with counters and flags visible one cycle after the accepting edge.
REQ-031 A beat accepted on the edge that enters DONE SHALL be fully checked and counted.

Reset
REQ-032 On rst=1 at a clock edge the FSM SHALL go to IDLE with S_AXIS_tready=0, busy=0, done=0, frame_cnt=0, err_cnt=0, err_flags=0, expected data=0 and beat index=0, and rst SHALL take priority over start and over beats in flight; reset mid-run SHALL abandon the run.

Configuration
REQ-033 With macro AXIS_CHK_BACKPRESSURE_EN defined, S_AXIS_tready in RUN SHALL equal bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset and on RUN entry) that advances every clock in RUN.
REQ-034 Without AXIS_CHK_BACKPRESSURE_EN, S_AXIS_tready SHALL be 1 for every cycle in RUN and the LFSR SHALL not exist.

Verification
REQ-035 Clean run: FRAME_LEN=16, NUM_FRAMES=4, tdata 0..63, tkeep=0xF, tlast on every 16th beat, tdest=0 -> done=1, frame_cnt=4, err_cnt=0, err_flags=0.
REQ-036 Data glitch: beat 5 carries 0xDEAD instead of 5, then beats continue from 0xDEAE -> err_flags=4'b0001, err_cnt=1.
REQ-037 Early tlast: tlast on beat 9 of frame 0, remaining beats framed correctly -> len flag set, frame_cnt counts the short frame, no further errors.
REQ-038 Bad keep and dest on one beat: tkeep=0x7 and tdest=3 -> err_flags=4'b1100, err_cnt=2.
REQ-039 Reset mid-run: rst asserted after 20 beats -> S_AXIS_tready=0 and all outputs zero on the next cycle; a following start and clean run pass.
REQ-040 Wrap and backpressure: DATA_WIDTH=8, NUM_FRAMES=20, data wrapping 0xFF->0x00, with AXIS_CHK_BACKPRESSURE_EN and random tvalid -> err_cnt=0, and tready is low on at least one RUN cycle.
